// File: rtl/audio_address_sequencer.sv
// audio_address_sequencer
// Walks the audio image in flash one 32-bit word at a time over Avalon-MM.
// Each word is split into two 16-bit samples, paced by sample_tick.
// Build option: define AUDIO_SEQ_LOOP_EN to wrap around at the image ends.
// Without it, the sequencer parks at the boundary and raises at_end.
module audio_address_sequencer #(
   parameter logic [22:0] START_ADDR = 23'h000000,
   parameter logic [22:0] END_ADDR   = 23'h07FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        play,
   input  logic        count_forward,
   input  logic        reset_address,
   input  logic        sample_tick,
   output logic        flash_mem_read,
   output logic [22:0] flash_mem_address,
   output logic [3:0]  flash_mem_byteenable,
   input  logic        flash_mem_waitrequest,
   input  logic [31:0] flash_mem_readdata,
   input  logic        flash_mem_readdatavalid,
   output logic [15:0] audio_sample,
   output logic        sample_valid,
   output logic        at_end
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT_DATA,
      EMIT0,
      WAIT_TICK2,
      EMIT1,
      ADVANCE
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [22:0] r_addr;
   logic [31:0] r_word;
   logic        r_dir;
   logic        r_rewind_pend;
   logic        r_read;
   logic [15:0] r_sample;
   logic        r_valid;

   logic        w_tick;
   logic        w_parked;
   logic        w_at_bound;
   logic        w_rewind_adv;
   logic [22:0] w_rewind_addr;
   logic [22:0] w_step_addr;

   // A tick only counts while playing.
   assign w_tick        = play & sample_tick;
   // The rewind target depends on the direction requested at the moment of the load.
   assign w_rewind_addr = count_forward ? START_ADDR : END_ADDR;
   // The boundary is the end of the image in the direction of the word just played.
   assign w_at_bound    = r_dir ? (r_addr == END_ADDR) : (r_addr == START_ADDR);
   assign w_step_addr   = r_dir ? (w_at_bound ? START_ADDR : r_addr + 23'd1)
                                : (w_at_bound ? END_ADDR   : r_addr - 23'd1);
   // A rewind that arrives in ADVANCE itself is applied right away, like a pending one.
   assign w_rewind_adv  = r_rewind_pend | reset_address;

`ifdef AUDIO_SEQ_LOOP_EN
   assign w_parked = 1'b0;
   assign at_end   = 1'b0;
`else
   logic r_at_end;
   logic r_end_fwd;

   assign w_parked = r_at_end;
   assign at_end   = r_at_end;

   // Boundary flag: set when ADVANCE reaches an end, cleared by a rewind
   // or by turning the direction away from the end that was reached.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_at_end  <= 1'b0;
         r_end_fwd <= 1'b1;
      end else if (r_state == ADVANCE && !w_rewind_adv && w_at_bound) begin
         r_at_end  <= 1'b1;
         r_end_fwd <= r_dir;
      end else if (r_at_end && (reset_address || (count_forward != r_end_fwd))) begin
         r_at_end  <= 1'b0;
      end
   end
`endif

   assign flash_mem_read       = r_read;
   assign flash_mem_address    = r_addr;
   assign flash_mem_byteenable = 4'hF;
   assign audio_sample         = r_sample;
   assign sample_valid         = r_valid;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state logic; a rewind in IDLE or WAIT_TICK2 beats a simultaneous tick.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:       if (!reset_address && w_tick && !w_parked) w_state_next = READ;
         READ:       if (!flash_mem_waitrequest) w_state_next = WAIT_DATA;
         WAIT_DATA:  if (flash_mem_readdatavalid) w_state_next = EMIT0;
         EMIT0:      w_state_next = WAIT_TICK2;
         WAIT_TICK2: begin
            if (reset_address)  w_state_next = IDLE;
            else if (w_tick)    w_state_next = EMIT1;
         end
         EMIT1:      w_state_next = ADVANCE;
         ADVANCE:    w_state_next = IDLE;
         default:    w_state_next = IDLE;
      endcase
   end

   // Datapath: registered outputs are loaded one cycle ahead of the state that shows them.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr        <= START_ADDR;
         r_word        <= '0;
         r_dir         <= 1'b1;
         r_rewind_pend <= 1'b0;
         r_read        <= 1'b0;
         r_sample      <= '0;
         r_valid       <= 1'b0;
      end else begin
         r_read  <= (w_state_next == READ);
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (reset_address) r_addr <= w_rewind_addr;
            end
            WAIT_TICK2: begin
               if (reset_address) begin
                  // Direct rewind supersedes any rewind still pending for this word.
                  r_addr        <= w_rewind_addr;
                  r_rewind_pend <= 1'b0;
               end else if (w_tick) begin
                  r_sample <= r_dir ? r_word[31:16] : r_word[15:0];
                  r_valid  <= 1'b1;
               end
            end
            ADVANCE: begin
               r_rewind_pend <= 1'b0;
               if (w_rewind_adv) begin
                  r_addr <= w_rewind_addr;
               end
`ifdef AUDIO_SEQ_LOOP_EN
               else begin
                  r_addr <= w_step_addr;
               end
`else
               else if (!w_at_bound) begin
                  r_addr <= w_step_addr;
               end
`endif
            end
            default: begin
               // READ, WAIT_DATA, EMIT0, EMIT1: a rewind is deferred to ADVANCE.
               if (reset_address) r_rewind_pend <= 1'b1;
               if (r_state == WAIT_DATA && flash_mem_readdatavalid) begin
                  r_word   <= flash_mem_readdata;
                  r_dir    <= count_forward;
                  r_sample <= count_forward ? flash_mem_readdata[15:0] : flash_mem_readdata[31:16];
                  r_valid  <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_audio_address_sequencer.sv
// Testbench for audio_address_sequencer: flash responder plus scoreboard of
// expected read addresses and samples, driven from a single test sequence.
module tb_audio_address_sequencer;

   localparam logic [22:0] START = 23'd0;
   localparam logic [22:0] ENDA  = 23'd12;

   logic        clk = 1'b0;
   logic        reset;
   logic        play;
   logic        count_forward;
   logic        reset_address;
   logic        sample_tick;
   logic        flash_mem_read;
   logic [22:0] flash_mem_address;
   logic [3:0]  flash_mem_byteenable;
   logic        flash_mem_waitrequest;
   logic [31:0] flash_mem_readdata;
   logic        flash_mem_readdatavalid;
   logic [15:0] audio_sample;
   logic        sample_valid;
   logic        at_end;

   int checks = 0;
   int errors = 0;
   logic [22:0] exp_addr_q[$];
   logic [15:0] exp_smp_q[$];
   int stall_cfg = 0;
   int lat_cfg = 0;
   int reads_count = 0;
   int valid_count = 0;
   int last_len = 0;
   logic [22:0] m_addr;
   bit          m_at_end;

   always #5 clk = ~clk;

   audio_address_sequencer #(.START_ADDR(START), .END_ADDR(ENDA)) dut (
      .clk(clk), .reset(reset), .play(play), .count_forward(count_forward),
      .reset_address(reset_address), .sample_tick(sample_tick),
      .flash_mem_read(flash_mem_read), .flash_mem_address(flash_mem_address),
      .flash_mem_byteenable(flash_mem_byteenable), .flash_mem_waitrequest(flash_mem_waitrequest),
      .flash_mem_readdata(flash_mem_readdata), .flash_mem_readdatavalid(flash_mem_readdatavalid),
      .audio_sample(audio_sample), .sample_valid(sample_valid), .at_end(at_end)
   );

   function automatic logic [31:0] word_of(input logic [22:0] a);
      if (a == 23'd0) return 32'hBBBBAAAA;
      if (a == 23'd5) return 32'h22221111;
      return {8'hC0, a[7:0], 8'h30, a[7:0]};
   endfunction

   // Flash responder and output monitor, evaluated on the falling edge.
   initial begin : flash_and_monitor
      bit          in_read;
      bit          pend;
      int          stall_left;
      int          lat_left;
      int          cur_len;
      logic [22:0] first_addr;
      logic [31:0] pend_data;
      logic [22:0] ea;
      logic [15:0] es;
      in_read = 0; pend = 0; stall_left = 0; lat_left = 0; cur_len = 0;
      first_addr = '0; pend_data = '0;
      flash_mem_waitrequest = 1'b0;
      flash_mem_readdatavalid = 1'b0;
      flash_mem_readdata = '0;
      forever begin
         @(negedge clk);
         flash_mem_readdatavalid = 1'b0;
         if (pend) begin
            if (lat_left == 0) begin
               flash_mem_readdatavalid = 1'b1;
               flash_mem_readdata = pend_data;
               pend = 0;
            end else begin
               lat_left--;
            end
         end
         if (flash_mem_read === 1'b1) begin
            if (!in_read) begin
               in_read = 1; stall_left = stall_cfg; first_addr = flash_mem_address; cur_len = 0;
            end else begin
               checks++;
               if (flash_mem_address !== first_addr) begin
                  errors++;
                  $display("FAIL addr_stable: address %h during READ, required %h", flash_mem_address, first_addr);
               end
            end
            cur_len++;
            if (stall_left > 0) begin
               flash_mem_waitrequest = 1'b1;
               stall_left--;
            end else begin
               flash_mem_waitrequest = 1'b0;
               in_read = 0; last_len = cur_len; reads_count++;
               pend = 1; lat_left = lat_cfg; pend_data = word_of(flash_mem_address);
               checks++;
               if (exp_addr_q.size() == 0) begin
                  errors++;
                  $display("FAIL read_addr: unexpected read at %h, no read required", flash_mem_address);
               end else begin
                  ea = exp_addr_q.pop_front();
                  if (flash_mem_address !== ea) begin
                     errors++;
                     $display("FAIL read_addr: got %h, required %h", flash_mem_address, ea);
                  end else begin
                     $display("read   addr=%h", flash_mem_address);
                  end
               end
            end
         end else begin
            flash_mem_waitrequest = 1'b0;
         end
         if (sample_valid === 1'b1) begin
            valid_count++;
            checks++;
            if (exp_smp_q.size() == 0) begin
               errors++;
               $display("FAIL sample: unexpected sample %h, no sample required", audio_sample);
            end else begin
               es = exp_smp_q.pop_front();
               if (audio_sample !== es) begin
                  errors++;
                  $display("FAIL sample: got %h, required %h", audio_sample, es);
               end else begin
                  $display("sample data=%h", audio_sample);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic pulse_tick();
      step(); sample_tick = 1'b1;
      step(); sample_tick = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (sample_valid !== 1'b1 && n < 50) begin
         step(); n++;
      end
      checks++;
      if (sample_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s: sample_valid=%b after %0d cycles, required 1", name, sample_valid, n);
      end
   endtask

   task automatic model_advance(input bit fwd);
      if (fwd) begin
         if (m_addr == ENDA) begin
`ifdef AUDIO_SEQ_LOOP_EN
            m_addr = START;
`else
            m_at_end = 1;
`endif
         end else m_addr = m_addr + 23'd1;
      end else begin
         if (m_addr == START) begin
`ifdef AUDIO_SEQ_LOOP_EN
            m_addr = ENDA;
`else
            m_at_end = 1;
`endif
         end else m_addr = m_addr - 23'd1;
      end
   endtask

   task automatic do_word(input bit fwd);
      logic [31:0] w;
      w = word_of(m_addr);
      count_forward = fwd;
      exp_addr_q.push_back(m_addr);
      exp_smp_q.push_back(fwd ? w[15:0] : w[31:16]);
      exp_smp_q.push_back(fwd ? w[31:16] : w[15:0]);
      pulse_tick(); wait_valid("emit0");
      pulse_tick(); wait_valid("emit1");
      model_advance(fwd);
      idle(2);
   endtask

   task automatic rewind(input bit cf);
      step(); count_forward = cf; reset_address = 1'b1;
      step(); reset_address = 1'b0;
      m_addr = cf ? START : ENDA;
      m_at_end = 0;
   endtask

   task automatic check_addr(input string name);
      checks++;
      if (flash_mem_address !== m_addr) begin
         errors++;
         $display("FAIL %s: address %h, required %h", name, flash_mem_address, m_addr);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; play = 1'b0; count_forward = 1'b1; reset_address = 1'b0; sample_tick = 1'b0;
      idle(3);
      m_addr = START; m_at_end = 0;
      checks++;
      if (flash_mem_read !== 1'b0 || sample_valid !== 1'b0 || at_end !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: read=%b valid=%b at_end=%b, required 0 0 0", flash_mem_read, sample_valid, at_end);
      end
      checks++;
      if (audio_sample !== 16'h0000) begin
         errors++;
         $display("FAIL reset_sample: got %h, required 0000", audio_sample);
      end
      checks++;
      if (flash_mem_byteenable !== 4'hF) begin
         errors++;
         $display("FAIL byteenable: got %h, required F", flash_mem_byteenable);
      end
      check_addr("reset_addr");
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_forward();
      int n;
      play = 1'b1; count_forward = 1'b1;
      exp_addr_q.push_back(m_addr);
      exp_smp_q.push_back(16'hAAAA);
      exp_smp_q.push_back(16'hBBBB);
      pulse_tick();
      n = 1;
      while (sample_valid !== 1'b1 && n < 50) begin
         step(); n++;
      end
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL first_latency: sample_valid after %0d cycles, required 3", n);
      end
      pulse_tick();
      checks++;
      if (sample_valid !== 1'b1) begin
         errors++;
         $display("FAIL tick2_latency: sample_valid=%b one cycle after tick, required 1", sample_valid);
      end
      wait_valid("fwd_emit1");
      model_advance(1);
      idle(2);
      check_addr("fwd_next_addr");
   endtask

   task automatic test_backward();
      repeat (4) do_word(1);
      check_addr("walk_to_5");
      do_word(0);
      check_addr("bwd_next_addr");
   endtask

   task automatic test_stall_pause();
      logic [31:0] w;
      int r0, v0, n;
      w = word_of(m_addr);
      count_forward = 1'b1; play = 1'b1; stall_cfg = 3; lat_cfg = 1;
      exp_addr_q.push_back(m_addr);
      exp_smp_q.push_back(w[15:0]);
      exp_smp_q.push_back(w[31:16]);
      r0 = reads_count;
      pulse_tick();
      pulse_tick();
      n = 0;
      while (reads_count == r0 && n < 20) begin
         step(); n++;
      end
      step(); play = 1'b0;
      wait_valid("stall_emit0");
      checks++;
      if (last_len != 4) begin
         errors++;
         $display("FAIL stall_len: read held %0d cycles, required 4", last_len);
      end
      v0 = valid_count;
      repeat (3) pulse_tick();
      idle(3);
      checks++;
      if (valid_count != v0) begin
         errors++;
         $display("FAIL pause_hold: %0d samples while paused, required 0", valid_count - v0);
      end
      play = 1'b1;
      pulse_tick();
      wait_valid("stall_emit1");
      model_advance(1);
      idle(2);
      stall_cfg = 0; lat_cfg = 0;
      check_addr("stall_next_addr");
   endtask

   task automatic test_rewind();
      logic [31:0] w;
      int v0, r0;
      repeat (5) do_word(1);
      check_addr("walk_to_10");
      w = word_of(m_addr);
      count_forward = 1'b1;
      exp_addr_q.push_back(m_addr);
      exp_smp_q.push_back(w[15:0]);
      exp_smp_q.push_back(w[31:16]);
      pulse_tick();
      step(); reset_address = 1'b1;
      step(); reset_address = 1'b0;
      wait_valid("rw_emit0");
      pulse_tick();
      wait_valid("rw_emit1");
      idle(2);
      m_addr = START;
      check_addr("rewind_pend_addr");
      w = word_of(m_addr);
      exp_addr_q.push_back(m_addr);
      exp_smp_q.push_back(w[15:0]);
      pulse_tick();
      wait_valid("wt2_emit0");
      step(); count_forward = 1'b0; reset_address = 1'b1;
      step(); reset_address = 1'b0; count_forward = 1'b1;
      v0 = valid_count;
      idle(3);
      checks++;
      if (valid_count != v0) begin
         errors++;
         $display("FAIL wt2_no_emit1: %0d samples after rewind, required 0", valid_count - v0);
      end
      m_addr = ENDA;
      check_addr("wt2_rewind_addr");
      r0 = reads_count;
      step(); count_forward = 1'b1; reset_address = 1'b1; sample_tick = 1'b1;
      step(); reset_address = 1'b0; sample_tick = 1'b0;
      idle(3);
      checks++;
      if (reads_count != r0) begin
         errors++;
         $display("FAIL rewind_beats_tick: %0d reads, required 0", reads_count - r0);
      end
      m_addr = START;
      check_addr("rewind_tick_addr");
      do_word(1);
   endtask

   task automatic test_boundary();
      int r0;
      rewind(0);
      check_addr("bnd_rewind_end");
      do_word(1);
      checks++;
      if (at_end !== m_at_end) begin
         errors++;
         $display("FAIL at_end_set: got %b, required %b", at_end, m_at_end);
      end
      check_addr("bnd_after_end");
`ifndef AUDIO_SEQ_LOOP_EN
      r0 = reads_count;
      repeat (3) begin
         pulse_tick(); idle(1);
      end
      idle(3);
      checks++;
      if (reads_count != r0) begin
         errors++;
         $display("FAIL parked_reads: %0d reads while parked, required 0", reads_count - r0);
      end
`else
      r0 = 0;
`endif
      rewind(1);
      checks++;
      if (at_end !== m_at_end) begin
         errors++;
         $display("FAIL at_end_rewind_clear: got %b, required %b", at_end, m_at_end);
      end
      do_word(1);
      rewind(0);
      do_word(1);
      count_forward = 1'b0;
      m_at_end = 0;
      idle(2);
      checks++;
      if (at_end !== m_at_end) begin
         errors++;
         $display("FAIL at_end_dir_clear: got %b, required %b", at_end, m_at_end);
      end
      do_word(0);
      check_addr("bnd_final_addr");
   endtask

   initial begin
      test_reset();
      test_forward();
      test_backward();
      test_stall_pause();
      test_rewind();
      test_boundary();
      idle(4);
      checks++;
      if (exp_addr_q.size() != 0 || exp_smp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d reads and %0d samples outstanding, required 0 0",
                  exp_addr_q.size(), exp_smp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/audio_address_sequencer.md
# audio_address_sequencer

Consumes the keyboard controller's `play`, `count_forward` and `reset_address` controls and walks the audio image in flash one 32-bit word at a time. It issues Avalon-MM reads to the flash controller and splits each word into two 16-bit samples. Each sample is presented to the audio output stage on a `sample_tick` strobe from the sample-rate divider. It sits between the keyboard controller and the audio codec interface.

## Interface
- `START_ADDR`, default 23'h000000: first word address of the audio image.
- `END_ADDR`, default 23'h07FFFF: last word address of the audio image; END_ADDR > START_ADDR.
- `clk`  in  1  system clock; the sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `play`  in  1  level; 1 = consume sample ticks, 0 = pause.
- `count_forward`  in  1  level; 1 = ascending addresses, 0 = descending.
- `reset_address`  in  1  one-cycle pulse; rewind request.
- `sample_tick`  in  1  one-cycle pulse at the sample rate.
- `flash_mem_read`  out  1  Avalon read request.
- `flash_mem_address`  out  23  word address.
- `flash_mem_byteenable`  out  4  constant 4'hF.
- `flash_mem_waitrequest`  in  1  Avalon stall.
- `flash_mem_readdata`  in  32  read data.
- `flash_mem_readdatavalid`  in  1  read data valid.
- `audio_sample`  out  16  current sample, held between updates.
- `sample_valid`  out  1  one-cycle pulse when `audio_sample` updates.
- `at_end`  out  1  boundary reached, non-loop build only; constant 0 otherwise.

## Operation
- The state machine has seven states: IDLE, READ, WAIT_DATA, EMIT0, WAIT_TICK2, EMIT1 and ADVANCE.
- **IDLE:** when `play` and `sample_tick` are both high, go to READ.
- **READ:** `flash_mem_read`=1 with `flash_mem_address`=addr. Hold both until a cycle with `waitrequest`=0, then go to WAIT_DATA.
- **WAIT_DATA:** on `readdatavalid`, latch `readdata` into the word register and latch `count_forward` as `dir`. Then go to EMIT0.
- **EMIT0:** output the first half of the word and pulse `sample_valid`, then go to WAIT_TICK2.
  - `dir`=1: the first half is the low half [15:0].
  - `dir`=0: the first half is the high half [31:16].
- **WAIT_TICK2:** when `play` and `sample_tick` are both high, go to EMIT1.
- **EMIT1:** output the other half of the word, pulse `sample_valid`, then go to ADVANCE.
- **ADVANCE:** update addr and return to IDLE.
  - `dir`=1: addr+1; at END_ADDR, wrap to START_ADDR.
  - `dir`=0: addr−1; at START_ADDR, wrap to END_ADDR.
- **Pausing:** `play`=0 only stalls IDLE and WAIT_TICK2. A flash transaction in progress (READ or WAIT_DATA) always completes.
- **Dropped ticks:** a `sample_tick` arriving in any state other than IDLE or WAIT_TICK2 is dropped and is not queued.
- **Rewind in IDLE or WAIT_TICK2:** `reset_address` loads addr with START_ADDR if `count_forward`=1, else END_ADDR. The state goes to IDLE and the remaining half-word is discarded.
- **Rewind in READ, WAIT_DATA, EMIT0, EMIT1 or ADVANCE:** the pulse sets a `rewind_pend` flag. ADVANCE then applies the rewind load instead of the increment or decrement, and clears the flag.
- **Simultaneous rewind and tick in IDLE:** the rewind wins and the tick is dropped.

## Timing
- **Reset values:** addr=START_ADDR, state=IDLE, `flash_mem_read`=0, `audio_sample`=0, `sample_valid`=0, `at_end`=0, `rewind_pend`=0.
- All outputs are registered, except that `flash_mem_byteenable` is a constant.
- **Zero-wait latency:** tick seen in IDLE at cycle T0.
  - T1: `flash_mem_read`=1, with `waitrequest`=0.
  - T2: WAIT_DATA; `readdatavalid`=1 arrives.
  - T3: `sample_valid`=1 and `audio_sample` carries the first half.
- Each `waitrequest` cycle and each extra data-latency cycle adds one cycle to this latency.
- **Second sample:** `sample_valid` pulses one cycle after the WAIT_TICK2 tick is seen.
- `flash_mem_address` is stable for the whole READ interval.
- `reset` asserted mid-transaction abandons it. The flash controller is required to tolerate an orphaned `readdatavalid`, which IDLE ignores.

## Configuration
- Macro: `AUDIO_SEQ_LOOP_EN`.
- **Defined:** wrap-around as described; `at_end` is tied to 0.
- **Undefined:** at the boundary, ADVANCE does not wrap. Instead it holds addr, sets `at_end`=1 and parks in IDLE, ignoring ticks.
  - `at_end` clears on `reset_address`.
  - `at_end` also clears when `count_forward` changes to the direction pointing away from the boundary.
  - Once `at_end` clears, normal operation resumes.

## Test plan
- **Forward read:** reset; `play`=1, `count_forward`=1; flash returns 32'hBBBBAAAA at address 0 with zero wait.
  - The first tick yields `audio_sample`=16'hAAAA at T3.
  - The second tick yields 16'hBBBB.
  - addr becomes 1.
- **Backward read:** `count_forward`=0 from addr 5, word 32'h22221111.
  - Samples are output in the order 16'h2222, then 16'h1111.
  - The next read is at address 4.
- **Stall and pause:** hold `waitrequest`=1 for 3 cycles and drop `play` during WAIT_DATA.
  - `flash_mem_read` and the address stay stable for the whole stall.
  - EMIT0 still pulses.
  - While `play` is low, WAIT_TICK2 ignores ticks.
- **Rewind:** pulse `reset_address` in WAIT_DATA at addr 10, `count_forward`=1.
  - EMIT0 and EMIT1 still complete.
  - The next read is at START_ADDR.
  - A `reset_address` pulse in WAIT_TICK2 instead goes straight to IDLE with no EMIT1.
- **Boundary:** set END_ADDR=3, forward.
  - With `AUDIO_SEQ_LOOP_EN`: the read after address 3 is at address 0.
  - Without it: `at_end`=1 and no further `flash_mem_read` occurs until `reset_address`.
